// File: rtl/audio_codec_pkg.sv
// ============================================================================
// Module  : audio_codec_pkg
// Brief   : Shared types and constants for the WM8731 power-up sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_codec_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LD   = 4'd1,
    S_GO   = 4'd2,
    S_RD   = 4'd3,
    S_WT   = 4'd4,
    S_CHK  = 4'd5,
    S_NXT  = 4'd6,
    S_DLY  = 4'd7,
    S_FIN  = 4'd8
  } state_e;

  localparam logic [6:0] R0  = 7'd0;
  localparam logic [6:0] R1  = 7'd1;
  localparam logic [6:0] R2  = 7'd2;
  localparam logic [6:0] R3  = 7'd3;
  localparam logic [6:0] R4  = 7'd4;
  localparam logic [6:0] R5  = 7'd5;
  localparam logic [6:0] R6  = 7'd6;
  localparam logic [6:0] R7  = 7'd7;
  localparam logic [6:0] R8  = 7'd8;
  localparam logic [6:0] R9  = 7'd9;
  localparam logic [6:0] R15 = 7'd15;

  localparam int INIT_LEN = 11;

  // Each word is {register index, 9-bit data}; R15 first resets the codec, R9 last activates it.
  localparam logic [15:0] INIT_TABLE [INIT_LEN] = '{
    {R15, 9'h000}, {R0, 9'h017}, {R1, 9'h017}, {R2, 9'h079},
    {R3,  9'h079}, {R4, 9'h012}, {R5, 9'h000}, {R6, 9'h000},
    {R7,  9'h002}, {R8, 9'h000}, {R9, 9'h001}
  };

  localparam logic [4:0] ADDR_DATA_DEF = 5'h01;
  localparam logic [4:0] ADDR_CTRL_DEF = 5'h00;
  localparam logic [4:0] ADDR_STAT_DEF = 5'h02;

endpackage

`default_nettype wire

// File: rtl/audio_init_rom.sv
// ============================================================================
// Module  : audio_init_rom
// Brief   : Combinational step -> WM8731 register word lookup with last flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_init_rom
  import audio_codec_pkg::*;
(
  input  logic [3:0]  step_i,
  output logic [15:0] word_o,
  output logic        last_o
);

  always_comb begin
    word_o = 16'h0000;
    if (step_i < 4'(INIT_LEN)) begin
      word_o = INIT_TABLE[step_i];
    end
  end

  assign last_o = (step_i == 4'(INIT_LEN - 1));

endmodule

`default_nettype wire

// File: rtl/audio_codec_init_seq.sv
// ============================================================================
// Module  : audio_codec_init_seq
// Brief   : WM8731 power-up sequencer driving the controller's Avalon-MM port.
//           Optional busy-poll timeout: define AUDIO_INIT_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_codec_init_seq
  import audio_codec_pkg::*;
#(
  parameter int         SYSCLK      = 50,
  parameter int         POST_RST_US = 10,
  parameter bit         AUTO_START  = 1'b1,
  parameter logic [4:0] ADDR_DATA   = ADDR_DATA_DEF,
  parameter logic [4:0] ADDR_CTRL   = ADDR_CTRL_DEF,
  parameter logic [4:0] ADDR_STAT   = ADDR_STAT_DEF,
  parameter int         BUSY_BIT    = 0,
  parameter int         RD_LAT      = 1,
  parameter int         TIMEOUT_CYC = 1 << 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  avm_address,
  output logic        avm_select,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  step
);

  localparam int DLY_CYC = SYSCLK * POST_RST_US;
  localparam int DLY_W   = (DLY_CYC < 2) ? 1 : $clog2(DLY_CYC);

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gap_q, gap_d;
  logic             stat_q, stat_d;
  logic             auto_q;
  logic [1:0]       wcnt_q, wcnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [15:0]      rom_word;
  logic             rom_last;
  logic             start_w;
  logic [31:0]      unused_rd;

  audio_init_rom u_rom (
    .step_i (step_q),
    .word_o (rom_word),
    .last_o (rom_last)
  );

  assign start_w   = start | (AUTO_START & auto_q);
  assign unused_rd = avm_readdata;

`ifdef AUDIO_INIT_TIMEOUT_EN
  localparam logic [20:0] TMO_LIM = 21'(TIMEOUT_CYC);

  logic [19:0] poll_q, poll_d;
  logic [20:0] poll_inc;
  logic        error_q, error_d;

  assign poll_inc = {1'b0, poll_q} + 21'd1;
  assign error    = error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_q  <= '0;
      error_q <= 1'b0;
    end else begin
      poll_q  <= poll_d;
      error_q <= error_d;
    end
  end
`else
  logic [20:0] unused_tmo;

  assign unused_tmo = 21'(TIMEOUT_CYC);
  assign error      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= 1'b0;
      stat_q  <= 1'b0;
      auto_q  <= 1'b1;
      wcnt_q  <= 2'd0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gap_q   <= gap_d;
      stat_q  <= stat_d;
      auto_q  <= 1'b0;
      wcnt_q  <= wcnt_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    busy_d        = busy_q;
    done_d        = done_q;
    gap_d         = 1'b0;
    stat_d        = stat_q;
    wcnt_d        = wcnt_q;
    dly_d         = dly_q;
    avm_address   = 5'h00;
    avm_select    = 1'b0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = 32'h0;
`ifdef AUDIO_INIT_TIMEOUT_EN
    poll_d        = poll_q;
    error_d       = error_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_w) begin
          done_d  = 1'b0;
          step_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = S_LD;
`ifdef AUDIO_INIT_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end
      // LD and GO each spend a second, silent cycle so strobes never abut.
      S_LD: begin
`ifdef AUDIO_INIT_TIMEOUT_EN
        poll_d = '0;
`endif
        if (!gap_q) begin
          avm_address   = ADDR_DATA;
          avm_select    = 1'b1;
          avm_write     = 1'b1;
          avm_writedata = {16'h0000, rom_word};
          gap_d         = 1'b1;
        end else begin
          state_d = S_GO;
        end
      end
      S_GO: begin
        if (!gap_q) begin
          avm_address   = ADDR_CTRL;
          avm_select    = 1'b1;
          avm_write     = 1'b1;
          avm_writedata = 32'h1;
          gap_d         = 1'b1;
        end else begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        avm_address = ADDR_STAT;
        avm_select  = 1'b1;
        avm_read    = 1'b1;
        wcnt_d      = 2'd0;
        state_d     = S_WT;
      end
      // Read data is valid in the last wait cycle; latch the busy bit there.
      S_WT: begin
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == 2'(RD_LAT - 1)) begin
          stat_d  = avm_readdata[BUSY_BIT];
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (stat_q) begin
`ifdef AUDIO_INIT_TIMEOUT_EN
          if (poll_inc >= TMO_LIM) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            poll_d  = poll_inc[19:0];
            state_d = S_RD;
          end
`else
          state_d = S_RD;
`endif
        end else begin
          state_d = S_NXT;
        end
      end
      S_NXT: begin
        if (step_q == 4'd0) begin
          dly_d   = '0;
          state_d = S_DLY;
        end else if (rom_last) begin
          state_d = S_FIN;
        end else begin
          step_d  = step_q + 4'd1;
          state_d = S_LD;
        end
      end
      S_DLY: begin
        if (dly_q == DLY_W'(DLY_CYC - 1)) begin
          step_d  = 4'd1;
          state_d = S_LD;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;

endmodule

`default_nettype wire
